// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory slave (dmem_wait_ctrl and dmem_array).
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WAIT_MAX = 15;

    // Number of byte-offset address bits for a DATA_W-wide word.
    function automatic int unsigned lane_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables and a registered read port.
module dmem_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned LANES      = DATA_W / 8,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LANES-1:0]  be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end else if (clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory slave: valid/ready request, programmable wait states, error response.
// Optional access counters enabled by defining DMEM_PERF_CNT_EN.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wen,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [31:0]         cnt_rd,
    output logic [31:0]         cnt_wr,
    output logic [31:0]         cnt_err
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = lane_bits(DATA_W);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned WAITS = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;

    state_t            state, nxt;
    logic [3:0]        wcnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LANES-1:0]  wen_q;

    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [LANES-1:0]  acc_wen;
    logic [ADDR_W-1:0] word;
    logic              accept, commit, acc_err, acc_wr;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;

    // With zero wait states the commit edge is also the accept edge,
    // so the access is taken straight from the request port.
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_wen   = (state == IDLE) ? req_wen   : wen_q;

    assign word    = acc_addr >> OFF_W;
    assign acc_wr  = |acc_wen;
    assign acc_err = ((acc_addr & ADDR_W'(LANES - 1)) != '0) ||
                     (64'(word) >= 64'(DEPTH_WORDS));

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req_valid) nxt = (WAITS == 0) ? RESP : WAIT;
            WAIT:    if (wcnt == '0) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Reset on the commit edge suppresses the write and the response.
    assign commit = ~rst & (nxt == RESP) & (state != RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                wcnt <= (WAITS == 0) ? '0 : 4'(WAITS - 1);
            end else if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            if (commit) begin
                rsp_err <= acc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wen_q   <= req_wen;
        end
    end

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .rd_en (commit & ~acc_err & ~acc_wr),
        .wr_en (commit & ~acc_err & acc_wr),
        .clr   (commit & (acc_err | acc_wr)),
        .idx   (word[IDX_W-1:0]),
        .be    (acc_wen),
        .wdata (acc_wdata),
        .rdata (rsp_rdata)
    );

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_q, wr_q, er_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            wr_q <= '0;
            er_q <= '0;
        end else if (commit) begin
            if (acc_err) begin
                if (er_q != '1) er_q <= er_q + 1'b1;
            end else if (acc_wr) begin
                if (wr_q != '1) wr_q <= wr_q + 1'b1;
            end else begin
                if (rd_q != '1) rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign cnt_rd  = rd_q;
    assign cnt_wr  = wr_q;
    assign cnt_err = er_q;
`else
    assign cnt_rd  = '0;
    assign cnt_wr  = '0;
    assign cnt_err = '0;
`endif

endmodule

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
- Synthesizable, parametrised data-memory slave for the RV32I core.
- Successor to the bench-only word-write RAM model: adds byte-lane writes, a valid/ready request handshake, programmable wait states, and an error response for misaligned or out-of-range accesses.
- Sits between the core data port and on-chip RAM. Also used as the data-memory model in integration benches.

Parameters:
- ADDR_W, 32, request byte-address width.
- DATA_W, 32, data width; multiple of 8, power of two.
- DEPTH_WORDS, 1024, storage depth in DATA_W words; power of two.
- WAIT_CYCLES, 0, extra stall cycles per access, 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  slave can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wen  in  DATA_W/8  byte-lane write enables; all-zero means read.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  access rejected; valid with rsp_valid.
- cnt_rd  out  32  completed-read count (optional feature).
- cnt_wr  out  32  completed-write count (optional feature).
- cnt_err  out  32  error count (optional feature).

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter 0, cnt_* = 0. Storage contents are not affected by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept on req_valid & req_ready; latch addr, wdata, wen.
  - IDLE -> WAIT if WAIT_CYCLES>0; IDLE -> RESP if WAIT_CYCLES=0.
  - WAIT: counter loads WAIT_CYCLES-1 on accept and decrements each cycle. Leave for RESP when counter==0.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- req_ready=0 in WAIT and RESP; requests are ignored there. The master holds its request until accepted.
- Latency: for a request accepted in cycle N, rsp_valid is high in cycle N+1+WAIT_CYCLES. Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Commit edge: the edge entering RESP.
  - Writes: each lane i with wen[i]=1 updates byte i of word addr>>log2(DATA_W/8). Other lanes are unchanged.
  - Reads: rsp_rdata is registered from storage at the same edge.
- Error condition: low log2(DATA_W/8) address bits nonzero, or word index >= DEPTH_WORDS. On error:
  - no storage write;
  - rsp_err=1, rsp_rdata=0;
  - same latency as a normal access.
- Address bits above the index range are checked, not aliased.
- Read-after-write: the next access is accepted no earlier than N+2+WAIT_CYCLES and observes the written data.
- rsp_rdata and rsp_err hold their values after RESP until the next RESP. They are meaningful only while rsp_valid=1.
- rst asserted in WAIT or RESP: return to IDLE, no response. If rst coincides with the commit edge, rst wins and no write occurs.
- req_valid asserted during rst is not accepted.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - cnt_rd, cnt_wr, cnt_err increment at each RESP entry of the matching kind (error accesses count only in cnt_err).
  - Counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: cnt_* tied to 0; no counter flops.

Decomposition:
- Package dmem_pkg:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - helper constant for lane-count/offset-width derivation;
  - WAIT_CYCLES upper bound (15).
- Sub-module dmem_array: DEPTH_WORDS x DATA_W storage with per-byte write enable and registered read.
- dmem_wait_ctrl holds the FSM, address checking, wait counter and counters.

Test Plan:
- Defaults, WAIT_CYCLES=0: write 0x1234_5678 to 0x10 with wen=4'b1111, then read 0x10. rsp_valid one cycle after each accept; read returns 0x1234_5678, rsp_err=0.
- Byte lanes: 0x10 holds 0x1234_5678; write wdata=0xAABB_CCDD, wen=4'b0101; read back 0x12BB_56DD.
- WAIT_CYCLES=2: accept in cycle N gives rsp_valid in N+3. req_ready=0 for N+1..N+3 while req_valid stays high; the second request is accepted at N+4.
- Errors: read 0x12 returns rsp_err=1, rsp_rdata=0. Write 0x1000 (DEPTH_WORDS=1024) returns rsp_err=1, and a later read of 0x0 shows no change.
- Reset: with WAIT_CYCLES=3, pulse rst one cycle before the commit edge of a write of 0xFFFF_FFFF to 0x20. No rsp_valid; a later read of 0x20 returns the prior value.
- With DMEM_PERF_CNT_EN: 3 reads, 2 writes, 1 error give cnt_rd=3, cnt_wr=2, cnt_err=1; rst clears all counters to 0.
